// File: rtl/cmsdk_mcu_ahb_cmd_master.sv
// ---------------------------------------------------------------------------
// cmsdk_mcu_ahb_cmd_master
//
// AHB initiator that turns a valid/ready command stream into single NONSEQ
// transfers and returns exactly one response per command, in acceptance order.
// Address and data phases are pipelined, so back-to-back commands give one
// transfer per cycle with zero wait states. Wait states and the two-cycle
// ERROR response are handled. RETRY/SPLIT are reported as errors and are not
// retried.
//
// Ports:
//   HCLK, HRESET        clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (accepted on valid & ready)
//   cmd_write           1 = write, 0 = read
//   cmd_addr            byte address
//   cmd_size            HSIZE encoding (0/1/2 legal)
//   cmd_wdata           lane-aligned write data
//   rsp_valid           one-cycle response pulse, no backpressure
//   rsp_error           response is an error
//   rsp_rdata           read data for OKAY reads, 0 for writes/illegal commands
//   HADDR..HWDATA       registered AHB initiator outputs
//   HRDATA/HREADY/HRESP AHB returns from the slave side
// ---------------------------------------------------------------------------
module cmsdk_mcu_ahb_cmd_master #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_error,
    output logic [31:0]           rsp_rdata,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_NONSEQ = 2'b10
    } trans_t;

    trans_t      trans_q;     // NONSEQ means an address phase is on the bus
    logic        data_busy;   // data phase outstanding
    logic        data_write;  // write flag of the outstanding data phase
    logic        err2;        // second ERROR cycle pending
    logic        retry_pend;  // pipelined transfer was cancelled by an ERROR
    logic [31:0] addr_wdata;  // wdata of the command in its address phase

    logic addr_busy;
    logic resp_bad;
    logic err_first;
    logic addr_done;
    logic data_done;
    logic cmd_legal;
    logic bus_ready;
    logic accept;

    assign HTRANS    = trans_q;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VALUE;
    assign HMASTLOCK = 1'b0;

    assign addr_busy = (trans_q == TR_NONSEQ);
    assign resp_bad  = (HRESP != 2'b00);
    // First cycle of a two-cycle non-OKAY response
    assign err_first = data_busy & ~HREADY & resp_bad;
    assign addr_done = addr_busy & HREADY;
    assign data_done = data_busy & HREADY;

    always_comb begin
        cmd_legal = 1'b0;
        case (cmd_size)
            3'd0:    cmd_legal = 1'b1;
            3'd1:    cmd_legal = ~cmd_addr[0];
            3'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
            default: cmd_legal = 1'b0;
        endcase
    end

    // A legal command may enter while the current address phase completes.
    // Illegal commands are answered locally, so they wait for an empty
    // pipeline to keep responses in order and one per cycle.
    assign bus_ready = ~HRESET & ~err2 & ~err_first & (~addr_busy | HREADY);
    assign cmd_ready = bus_ready & (cmd_legal | (~addr_busy & ~data_busy));
    assign accept    = cmd_valid & cmd_ready;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            trans_q    <= TR_IDLE;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HSIZE      <= 3'b000;
            HWDATA     <= 32'h0;
            data_busy  <= 1'b0;
            data_write <= 1'b0;
            err2       <= 1'b0;
            retry_pend <= 1'b0;
            addr_wdata <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_error  <= 1'b0;
            rsp_rdata  <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= 32'h0;

            // Data phase completion produces the response for its command.
            // A non-OKAY response ends here too, on its second cycle.
            if (data_done) begin
                rsp_valid <= 1'b1;
                rsp_error <= resp_bad;
                rsp_rdata <= data_write ? 32'h0 : HRDATA;
            end

            // Address phase completion hands the command to the data phase
            if (addr_done) begin
                data_busy  <= 1'b1;
                data_write <= HWRITE;
                if (HWRITE)
                    HWDATA <= addr_wdata;
            end else if (data_done) begin
                data_busy <= 1'b0;
            end

            if (err_first) begin
                // Drop the pipelined address phase for the second error
                // cycle; its attributes stay in HADDR/HWRITE/HSIZE/addr_wdata.
                err2 <= 1'b1;
                if (addr_busy) begin
                    trans_q    <= TR_IDLE;
                    retry_pend <= 1'b1;
                end
            end else if (err2 && HREADY) begin
                err2 <= 1'b0;
                if (retry_pend) begin
                    trans_q    <= TR_NONSEQ;
                    retry_pend <= 1'b0;
                end
            end else if (accept) begin
                if (cmd_legal) begin
                    trans_q    <= TR_NONSEQ;
                    HADDR      <= cmd_addr;
                    HWRITE     <= cmd_write;
                    HSIZE      <= cmd_size;
                    addr_wdata <= cmd_wdata;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_error <= 1'b1;
                    rsp_rdata <= 32'h0;
                end
            end else if (addr_done) begin
                trans_q <= TR_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cmsdk_mcu_ahb_cmd_master.sv
// ---------------------------------------------------------------------------
// Bench for cmsdk_mcu_ahb_cmd_master. A behavioural AHB slave answers bus
// transfers from its own memory; a transaction-level reference model predicts
// each response at command acceptance and a monitor checks responses in order.
// ---------------------------------------------------------------------------
module tb_cmsdk_mcu_ahb_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    cmsdk_mcu_ahb_cmd_master dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          acc_cnt  = 0;
    exp_t        exp_q[$];
    logic [31:0] ref_mem[64];
    logic [31:0] bus_mem[64];
    logic [31:0] cap_log[$];

    // slave configuration
    int          wait_cfg  = 0;
    bit          rand_wait = 0;
    bit          rand_err  = 0;

    function automatic bit is_err_addr(input logic [31:0] a);
        return a[31:28] == 4'hE;
    endfunction

    function automatic bit legal_cmd(input logic [2:0] s, input logic [31:0] a);
        if (s > 3'd2) return 1'b0;
        return (a % (32'd1 << s)) == 32'd0;
    endfunction

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 2) % 32'd64);
    endfunction

    task automatic step();
        @(negedge HCLK);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = d;
    endtask

    // Behavioural slave: decides each cycle's HREADY/HRESP/HRDATA at the
    // falling edge and records what the coming rising edge will do.
    initial begin : slave
        bit          dp_valid;
        logic [31:0] dp_addr;
        bit          dp_write, dp_err;
        logic [1:0]  dp_code;
        int          dp_wait;
        bit          err_ph;
        dp_valid = 0; dp_addr = 0; dp_write = 0; dp_err = 0; dp_code = 2'b01;
        dp_wait = 0; err_ph = 0;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                dp_valid = 0; err_ph = 0;
                HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
            end else begin
                HRDATA = $urandom;
                if (!dp_valid) begin
                    HREADY = 1'b1; HRESP = 2'b00;
                end else if (err_ph) begin
                    HREADY = 1'b1; HRESP = dp_code; HRDATA = 32'h0;
                end else if (dp_wait > 0) begin
                    HREADY = 1'b0; HRESP = 2'b00; dp_wait--;
                end else if (dp_err) begin
                    HREADY = 1'b0; HRESP = dp_code; err_ph = 1;
                end else begin
                    HREADY = 1'b1; HRESP = 2'b00;
                    if (!dp_write) HRDATA = bus_mem[midx(dp_addr)];
                end
                if (HREADY) begin
                    if (dp_valid && !dp_err && dp_write)
                        bus_mem[midx(dp_addr)] = HWDATA;
                    dp_valid = 0;
                    err_ph   = 0;
                    if (HTRANS == 2'b10) begin
                        dp_valid = 1;
                        dp_addr  = HADDR;
                        dp_write = HWRITE;
                        dp_err   = is_err_addr(HADDR);
                        dp_code  = rand_err ? 2'($urandom_range(1, 3)) : 2'b01;
                        dp_wait  = rand_wait ? int'($urandom_range(0, 2)) : wait_cfg;
                        cap_log.push_back(HADDR);
                    end
                end
            end
        end
    end

    // Reference model: predicts each command's response when it is accepted
    initial begin : acc_watch
        exp_t e;
        forever begin
            @(negedge HCLK);
            #3;
            if (!HRESET && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                acc_cnt++;
                e.err   = 1'b0;
                e.rdata = 32'h0;
                if (!legal_cmd(cmd_size, cmd_addr)) begin
                    e.err = 1'b1;
                    n_checks++;
                    if (exp_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL illegal_accept_busy: accepted with %0d outstanding, required 0",
                                 exp_q.size());
                    end
                end else if (is_err_addr(cmd_addr)) begin
                    e.err = 1'b1;
                end else if (cmd_write) begin
                    ref_mem[midx(cmd_addr)] = cmd_wdata;
                end else begin
                    e.rdata = ref_mem[midx(cmd_addr)];
                end
                exp_q.push_back(e);
            end
        end
    end

    // Response and bus-constant monitor
    initial begin : rsp_mon
        exp_t e;
        forever begin
            @(negedge HCLK);
            #1;
            if (!HRESET) begin
                n_checks++;
                if (HBURST !== 3'b000 || HMASTLOCK !== 1'b0 || HPROT !== 4'b0011 ||
                    !(HTRANS === 2'b00 || HTRANS === 2'b10)) begin
                    n_fail++;
                    $display("FAIL bus_const: HTRANS=%b HBURST=%b HPROT=%b HMASTLOCK=%b", HTRANS,
                             HBURST, HPROT, HMASTLOCK);
                end
                if (rsp_valid === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_unexpected: got err=%b rdata=%h, required no response",
                                 rsp_error, rsp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (rsp_error !== e.err || rsp_rdata !== e.rdata) begin
                            n_fail++;
                            $display("FAIL rsp_content: got err=%b rdata=%h, required err=%b rdata=%h",
                                     rsp_error, rsp_rdata, e.err, e.rdata);
                        end
                    end
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        cmd_valid = 1'b0;
        while ((exp_q.size() != 0 || HTRANS !== 2'b00) && n < 60) begin
            step();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || HTRANS !== 2'b00) begin
            n_fail++;
            $display("FAIL drain_%s: %0d responses outstanding, HTRANS=%b, required 0 and 00",
                     name, exp_q.size(), HTRANS);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        step();
        step();
        n_checks++;
        if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_error, rsp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%h HWDATA=%h rsp=%b/%b/%h, required all 0",
                     HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_error, rsp_rdata);
        end
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: cmd_ready=%b, required 0", cmd_ready);
        end
        HRESET = 1'b0;
        step();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: cmd_ready=%b, required 1", cmd_ready);
        end
    endtask

    task automatic test_single_read();
        int a0;
        bus_mem[1] = 32'hCAFEF00D;
        ref_mem[1] = 32'hCAFEF00D;
        step();
        a0 = acc_cnt;
        drive(1'b0, 32'h2000_0004, 3'd2, 32'h0);
        step();
        cmd_valid = 1'b0;
        n_checks++;
        if (acc_cnt != a0 + 1 || HTRANS !== 2'b10 || HADDR !== 32'h2000_0004 ||
            HWRITE !== 1'b0 || HSIZE !== 3'd2) begin
            n_fail++;
            $display("FAIL read_addr_phase: acc=%0d HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%0d, required acc=%0d 10 20000004 0 2",
                     acc_cnt - a0, HTRANS, HADDR, HWRITE, HSIZE, 1);
        end
        step();
        n_checks++;
        if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_data_phase: HTRANS=%b rsp_valid=%b, required 00 0", HTRANS, rsp_valid);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL read_rsp: valid=%b err=%b rdata=%h, required 1 0 cafef00d", rsp_valid,
                     rsp_error, rsp_rdata);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp_pulse: rsp_valid=%b, required 0", rsp_valid);
        end
        drain("single_read");
    endtask

    task automatic test_back_to_back();
        logic [31:0] adr[3];
        int a0;
        adr[0] = 32'h10; adr[1] = 32'h14; adr[2] = 32'h18;
        step();
        a0 = acc_cnt;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            if (k >= 1 && k <= 3) begin
                n_checks++;
                if (HTRANS !== 2'b10 || HADDR !== adr[k-1] || HWRITE !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_addr%0d: HTRANS=%b HADDR=%h, required 10 %h", k, HTRANS,
                             HADDR, adr[k-1]);
                end
            end
            if (k >= 2 && k <= 4) begin
                n_checks++;
                if (HWDATA !== 32'(k - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_wdata%0d: HWDATA=%h, required %0d", k, HWDATA, k - 1);
                end
            end
            if (k >= 3) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_rsp%0d: valid=%b err=%b, required 1 0", k, rsp_valid, rsp_error);
                end
            end
            if (k < 3) drive(1'b1, adr[k], 3'd2, 32'(k + 1));
            else cmd_valid = 1'b0;
        end
        n_checks++;
        if (acc_cnt != a0 + 3 || HTRANS !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_count: accepted=%0d HTRANS=%b, required 3 00", acc_cnt - a0, HTRANS);
        end
        drain("back_to_back");
    endtask

    task automatic test_wait_states();
        wait_cfg = 2;
        step();
        drive(1'b0, 32'h24, 3'd2, 32'h0);
        step();
        drive(1'b0, 32'h30, 3'd2, 32'h0);
        for (int k = 2; k <= 4; k++) begin
            step();
            cmd_valid = 1'b0;
            #1;
            n_checks++;
            if (HTRANS !== 2'b10 || HADDR !== 32'h30 || cmd_ready !== (k == 4) || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_cycle%0d: HTRANS=%b HADDR=%h cmd_ready=%b rsp_valid=%b, required 10 30 %b 0",
                         k, HTRANS, HADDR, cmd_ready, rsp_valid, (k == 4));
            end
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[9]) begin
            n_fail++;
            $display("FAIL wait_rsp: valid=%b rdata=%h, required 1 %h", rsp_valid, rsp_rdata, ref_mem[9]);
        end
        drain("wait_states");
        wait_cfg = 0;
    endtask

    task automatic test_error_cancel();
        cap_log.delete();
        step();
        drive(1'b1, 32'hE000_0010, 3'd2, 32'h55);
        step();
        drive(1'b0, 32'h28, 3'd2, 32'h0);
        step();
        cmd_valid = 1'b0;
        #1;
        n_checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h28 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cycle1: HTRANS=%b HADDR=%h cmd_ready=%b, required 10 28 0", HTRANS,
                     HADDR, cmd_ready);
        end
        step();
        n_checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h28 || HWRITE !== 1'b0 || cmd_ready !== 1'b0 ||
            rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cycle2: HTRANS=%b HADDR=%h HWRITE=%b cmd_ready=%b rsp_valid=%b, required 00 28 0 0 0",
                     HTRANS, HADDR, HWRITE, cmd_ready, rsp_valid);
        end
        step();
        n_checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h28 || rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin
            n_fail++;
            $display("FAIL err_reissue: HTRANS=%b HADDR=%h rsp=%b/%b, required 10 28 1/1", HTRANS,
                     HADDR, rsp_valid, rsp_error);
        end
        step();
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== ref_mem[10]) begin
            n_fail++;
            $display("FAIL err_read_rsp: valid=%b err=%b rdata=%h, required 1 0 %h", rsp_valid,
                     rsp_error, rsp_rdata, ref_mem[10]);
        end
        drain("error_cancel");
        n_checks++;
        if (cap_log.size() != 2 || cap_log[0] !== 32'hE000_0010 || cap_log[1] !== 32'h28) begin
            n_fail++;
            $display("FAIL err_bus_count: %0d address phases completed, required 2 (e0000010, 28)",
                     cap_log.size());
        end
    endtask

    task automatic test_misaligned();
        int a0;
        int n;
        logic [2:0] sz[2];
        logic [31:0] ad[2];
        sz[0] = 3'd2; ad[0] = 32'h102;
        sz[1] = 3'd3; ad[1] = 32'h0;
        for (int t = 0; t < 2; t++) begin
            cap_log.delete();
            step();
            drive(1'b0, 32'h30, 3'd2, 32'h0);
            step();
            drive(1'b0, ad[t], sz[t], 32'h0);
            a0 = acc_cnt;
            #1;
            n_checks++;
            if (cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_busy_ready%0d: cmd_ready=%b, required 0", t, cmd_ready);
            end
            n = 0;
            while (acc_cnt == a0 && n < 20) begin
                step();
                n++;
            end
            cmd_valid = 1'b0;
            n_checks++;
            if (acc_cnt == a0) begin
                n_fail++;
                $display("FAIL illegal_accept%0d: not accepted within 20 cycles", t);
            end else if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0 ||
                         HTRANS !== 2'b00) begin
                n_fail++;
                $display("FAIL illegal_rsp%0d: rsp=%b/%b/%h HTRANS=%b, required 1/1/0 00", t,
                         rsp_valid, rsp_error, rsp_rdata, HTRANS);
            end
            step();
            n_checks++;
            if (rsp_valid !== 1'b0 || HTRANS !== 2'b00 || cap_log.size() != 1) begin
                n_fail++;
                $display("FAIL illegal_no_bus%0d: rsp_valid=%b HTRANS=%b phases=%0d, required 0 00 1",
                         t, rsp_valid, HTRANS, cap_log.size());
            end
            drain("misaligned");
        end
    endtask

    task automatic test_reset_midflight();
        wait_cfg = 3;
        step();
        drive(1'b0, 32'h2C, 3'd2, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        HRESET = 1'b1;
        #1;
        exp_q.delete();
        n_checks++;
        if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_error, rsp_rdata} !== '0 ||
            cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_values: HTRANS=%b HADDR=%h HWDATA=%h rsp_valid=%b cmd_ready=%b, required all 0",
                     HTRANS, HADDR, HWDATA, rsp_valid, cmd_ready);
        end
        step();
        HRESET = 1'b0;
        wait_cfg = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin
                n_fail++;
                $display("FAIL midreset_quiet%0d: rsp_valid=%b HTRANS=%b, required 0 00", k,
                         rsp_valid, HTRANS);
            end
        end
        drive(1'b0, 32'h2C, 3'd2, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== ref_mem[11]) begin
            n_fail++;
            $display("FAIL midreset_next: rsp=%b/%b/%h, required 1/0/%h", rsp_valid, rsp_error,
                     rsp_rdata, ref_mem[11]);
        end
        drain("reset_midflight");
    endtask

    task automatic test_random();
        bit          holding;
        int          a0;
        int          r;
        logic [2:0]  s;
        logic [31:0] off;
        logic [31:0] base;
        rand_wait = 1;
        rand_err  = 1;
        holding   = 0;
        a0        = 0;
        for (int k = 0; k < 500; k++) begin
            step();
            if (holding && acc_cnt != a0) holding = 0;
            if (!holding) begin
                if ($urandom_range(0, 3) != 0) begin
                    r = int'($urandom_range(0, 15));
                    s = (r < 5) ? 3'd0 : (r < 10) ? 3'd1 : (r < 15) ? 3'd2 : 3'd3;
                    off = 32'($urandom_range(0, 255));
                    if ($urandom_range(0, 7) != 0 && s <= 3'd2)
                        off = off - (off % (32'd1 << s));
                    base = ($urandom_range(0, 7) == 0) ? 32'hE000_0000
                                                        : 32'h1000 * 32'($urandom_range(0, 3));
                    drive(1'($urandom_range(0, 1)), base + off, s, $urandom);
                    a0 = acc_cnt;
                    holding = 1;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        drain("random");
        rand_wait = 0;
        rand_err  = 0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : main
        HRESET    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_size  = 3'd0;
        cmd_wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end
        #1;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_error_cancel();
        test_misaligned();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
